// File: rtl/demux_pkg.sv
// Shared types and constants for the buffered 1-to-4 word demultiplexer.
package demux_pkg;
  localparam int NUM_CH     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int STAT_W     = 16;

  typedef logic [1:0] ch_sel_t;
  typedef logic [1:0] fifo_cnt_t;
endpackage

// File: rtl/demux_chan_fifo.sv
// One channel of the demux: 2-entry FIFO with 1-bit wrapping pointers and a 0..2 count.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [N-1:0]    wdata,
  output logic [N-1:0]    rdata,
  output fifo_cnt_t       count
);

  logic [N-1:0] mem_q [FIFO_DEPTH];
  logic [N-1:0] mem_d [FIFO_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  fifo_cnt_t    cnt_q, cnt_d;

  // The parent only asserts push when count < 2 and pop when count > 0.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/demux_1nto4n_buf.sv
// Buffered 1-to-4 demux: routes one N-bit word per cycle into per-channel 2-deep FIFOs.
// Optional DEMUX_STATS_EN adds per-channel pop counters (xfer_cnt) and a stall flag.
module demux_1nto4n_buf
  import demux_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N-1:0]             in_data,
  input  ch_sel_t                  in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*N-1:0]      out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] xfer_cnt,
  output logic                     stall
`endif
);

  fifo_cnt_t          cnt   [NUM_CH];
  logic [N-1:0]       rdata [NUM_CH];
  logic [NUM_CH-1:0]  push;
  logic [NUM_CH-1:0]  pop;

  // Ready looks only at registered occupancy, never at out_ready.
  assign in_ready = enable && !rst && (cnt[in_sel] < fifo_cnt_t'(DEPTH));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k]      = in_valid && in_ready && (in_sel == ch_sel_t'(k));
    assign out_valid[k] = enable && (cnt[k] != '0);
    assign pop[k]       = out_valid[k] && out_ready[k];

    demux_chan_fifo #(.N(N)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .wdata (in_data),
      .rdata (rdata[k]),
      .count (cnt[k])
    );

    assign out_data[k*N +: N] = rdata[k];
  end

`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] xfer_cnt_q [NUM_CH];
  logic [STAT_W-1:0] xfer_cnt_d [NUM_CH];

  // Counters wrap naturally at 16'hFFFF.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      xfer_cnt_d[k] = xfer_cnt_q[k] + STAT_W'(pop[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        xfer_cnt_q[k] <= '0;
      end
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
    assign xfer_cnt[k*STAT_W +: STAT_W] = xfer_cnt_q[k];
  end

  assign stall = in_valid && !in_ready && enable;
`endif

endmodule

// File: tb/tb_demux_1nto4n_buf.sv
// Directed bench for demux_1nto4n_buf: queue-based reference model plus literal spot checks.
module tb_demux_1nto4n_buf;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b1;
  logic [N-1:0]   in_data = '0;
  logic [1:0]     in_sel = 2'd0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [4*N-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
  logic [63:0]    xfer_cnt;
  logic           stall;
`endif

  int total = 0;
  int bad   = 0;

  demux_1nto4n_buf #(.N(N), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall     (stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per channel, at most two words each.
  logic [N-1:0] mq [4][$];
  bit           pushed [4];
  int           pops   [4];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          mq[k].delete();
          pushed[k] = 1'b0;
          pops[k]   = 0;
        end
      end else if (enable) begin
        bit do_pop [4];
        bit do_push[4];
        for (int k = 0; k < 4; k++) begin
          do_pop[k]  = (mq[k].size() > 0) && out_ready[k];
          do_push[k] = in_valid && (int'(in_sel) == k) && (mq[k].size() < 2);
        end
        for (int k = 0; k < 4; k++) begin
          if (do_pop[k]) begin
            void'(mq[k].pop_front());
            pops[k] = (pops[k] + 1) % 65536;
          end
          if (do_push[k]) begin
            mq[k].push_back(in_data);
            pushed[k] = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic exp_rdy;
        logic [3:0] exp_vld;
        exp_rdy = enable && (mq[in_sel].size() < 2);
        chk("model_in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
          exp_vld[k] = enable && (mq[k].size() > 0);
          if (mq[k].size() > 0)
            chk("model_head", {96'd0, out_data[k*N +: N]}, {96'd0, mq[k][0]});
          else if (!pushed[k])
            chk("model_idle_data", {96'd0, out_data[k*N +: N]}, 128'd0);
        end
        chk("model_out_valid", {124'd0, out_valid}, {124'd0, exp_vld});
`ifdef DEMUX_STATS_EN
        for (int k = 0; k < 4; k++)
          chk("model_xfer_cnt", {112'd0, xfer_cnt[k*16 +: 16]}, 128'(pops[k]));
        chk("model_stall", {127'd0, stall}, {127'd0, in_valid && enable && !exp_rdy});
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [1:0] sel, input logic [N-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {124'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    end

    // Single route to channel 2
    cyc();
    push1(2'd2, 32'hDEADBEEF);
    #1;
    chk("route_valid", {124'd0, out_valid}, 128'h4);
    chk("route_data", {96'd0, out_data[64 +: 32]}, 128'hDEADBEEF);

    // Fill channel 1, then offer a third word
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h1;
    cyc();
    in_data = 32'h2;
    cyc();
    in_data = 32'h3;
    #1;
    chk("full_ready", {127'd0, in_ready}, 128'd0);
    cyc(); cyc();
    #1;
    chk("full_head1", {96'd0, out_data[32 +: 32]}, 128'h1);
    out_ready = 4'b0010;
    #1;
    chk("full_ready_popping", {127'd0, in_ready}, 128'd0);
    cyc();
    #1;
    chk("after_pop_ready", {127'd0, in_ready}, 128'd1);
    chk("after_pop_head2", {96'd0, out_data[32 +: 32]}, 128'h2);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("head3", {96'd0, out_data[32 +: 32]}, 128'h3);
    chk("head3_valid", {127'd0, out_valid[1]}, 128'd1);
    cyc();
    out_ready = 4'b0000;
    #1;
    chk("ch1_drained", {127'd0, out_valid[1]}, 128'd0);

    // Streaming on channel 0
    out_ready = 4'b0001;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'hA000_0000 + 32'(i);
      #1;
      chk("stream_ready", {127'd0, in_ready}, 128'd1);
      if (i > 0) begin
        chk("stream_valid", {127'd0, out_valid[0]}, 128'd1);
        chk("stream_head", {96'd0, out_data[0 +: 32]}, 128'(32'hA000_0000 + 32'(i - 1)));
      end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("stream_last", {96'd0, out_data[0 +: 32]}, 128'hA000_0009);
    cyc();
    out_ready = 4'b0000;

    // Enable freeze with one word on channel 3
    push1(2'd3, 32'hC3);
    enable    = 1'b0;
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("freeze_valid", {124'd0, out_valid}, 128'd0);
      chk("freeze_ready", {127'd0, in_ready}, 128'd0);
      chk("freeze_data", {96'd0, out_data[96 +: 32]}, 128'hC3);
      cyc();
    end
    enable = 1'b1;
    #1;
    chk("thaw_valid", {124'd0, out_valid}, 128'hC);
    cyc();
    out_ready = 4'b0000;
    #1;
    chk("thaw_drained", {124'd0, out_valid}, 128'd0);

    // Load 2,1,0,2 words then reset asynchronously between edges
    push1(2'd0, 32'h600);
    push1(2'd0, 32'h601);
    push1(2'd1, 32'h602);
    push1(2'd3, 32'h603);
    push1(2'd3, 32'h604);
    #1;
    chk("preload_valid", {124'd0, out_valid}, 128'hB);
`ifdef DEMUX_STATS_EN
    chk("pre_rst_xfer", {64'd0, xfer_cnt}, {64'd0, 16'd1, 16'd1, 16'd3, 16'd10});
`endif
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {124'd0, out_valid}, 128'd0);
    chk("async_rst_ready", {127'd0, in_ready}, 128'd0);
`ifdef DEMUX_STATS_EN
    chk("async_rst_xfer", {64'd0, xfer_cnt}, 128'd0);
`endif
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", {124'd0, out_valid}, 128'd0);
    chk("post_rst_data", out_data, 128'd0);
    push1(2'd2, 32'h77);
    #1;
    chk("post_rst_push", {124'd0, out_valid}, 128'h4);
    chk("post_rst_head", {96'd0, out_data[64 +: 32]}, 128'h77);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1nto4n_buf.md
Name: demux_1Nto4N_buf

Overview:
- Buffered 1-to-4 demultiplexer for N-bit words: the routing inverse of the 4:1 datapath muxes.
- Accepts one word per cycle on a valid/ready input with a 2-bit destination select.
- Steers each word into one of four per-channel 2-entry FIFOs; each FIFO drains on its own valid/ready output.
- Used in the processor to fan out results (e.g. writeback/forwarding) to independent consumers without stalling unrelated channels.

Parameters:
- N, 32, data width in bits.
- DEPTH, 2, entries per channel FIFO (fixed at 2; other values unsupported).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- enable  input  1  global enable; 0 freezes all transfers.
- in_data  input  N  word to route.
- in_sel  input  2  destination channel 0..3.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block can accept the word on in_sel this cycle.
- out_data  output  4*N  channel k occupies bits [k*N +: N]; head of FIFO k.
- out_valid  output  4  bit k = channel k holds data and enable=1.
- out_ready  input  4  bit k = consumer k takes head this cycle.

Behaviour:
- Reset: asynchronous and active-high. Clears all FIFO occupancy counts, read/write pointers and storage to 0. in_ready=0 while rst=1. out_valid=0 and out_data=0 during and after reset until the first push.
- in_ready = enable && !rst && count[in_sel] < 2.
  - Depends only on registered count, enable and in_sel, never on out_ready (no combinational ready-through path).
- Push to channel k: in_valid && in_ready && in_sel==k at a rising edge. The word is written at wr_ptr[k]; count[k] increments.
- Pop from channel k: out_valid[k] && out_ready[k] at a rising edge. rd_ptr[k] advances; count[k] decrements.
- Latency: a word pushed at edge t is visible on out_data[k] with out_valid[k]=1 after edge t when its FIFO was empty. Otherwise it appears after the words ahead of it drain.
- Per-channel order is FIFO. No ordering is guaranteed across channels.
- Simultaneous push and pop on the same channel:
  - count 1: count stays 1 and data advances.
  - count 0: only the push occurs; the pop is impossible because out_valid=0.
  - count 2: the push is rejected because in_ready=0, even if a pop occurs the same cycle.
- Pointers are 1 bit each and wrap 1→0. count is 2 bits with range 0..2 and never exceeds 2.
- enable=0:
  - in_ready=0 and out_valid=0.
  - No push or pop; storage, pointers and counts are held.
  - out_data still shows the FIFO heads.
- Pushes and pops on different channels in the same cycle are fully independent.
- in_valid with in_ready=0: no state change. The source must hold its word.
- Reset asserted mid-operation: all buffered words are discarded immediately (asynchronous).

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Adds output port xfer_cnt (4*16 bits); bits [k*16 +: 16] count pops on channel k.
  - Counters wrap at 16'hFFFF→0 and clear on rst.
  - Adds output port stall (1 bit), high when in_valid && !in_ready && enable.
- Undefined: neither port nor its logic exists; the rest of the behaviour is identical.

Decomposition:
- Package demux_pkg:
  - NUM_CH=4, FIFO_DEPTH=2, STAT_W=16.
  - typedef logic [1:0] ch_sel_t.
  - typedef logic [1:0] fifo_cnt_t.
- Sub-module demux_chan_fifo, instantiated 4 times:
  - Parameter N; ports clk, rst, push, pop, wdata, rdata, count.
  - Holds one channel's 2-entry storage, pointers and count.
- Top-level: select decode, the in_ready mux, enable gating, output packing, and the optional stats logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → out_valid=4'b0000, out_data=0, in_ready=1 for any in_sel while enable=1.
- Single route: push 32'hDEADBEEF with in_sel=2, out_ready=0 → after 1 edge out_valid=4'b0100 and out_data[64+:32]=32'hDEADBEEF; other channels are unchanged.
- Full channel: push 32'h1 then 32'h2 to channel 1 with out_ready=0, then offer 32'h3 →
  - in_ready=0 on the third cycle and count stays 2.
  - Raising out_ready[1] pops 32'h1 then 32'h2 in order; 32'h3 is accepted on the cycle after the first pop.
- Streaming: back-to-back pushes to channel 0 with out_ready[0]=1 held → one word per cycle throughput, order preserved, no gaps after the first-cycle latency.
- Enable freeze: with 1 word buffered on channel 3, drop enable for 3 cycles with out_ready=4'b1111 → out_valid=0 and in_ready=0; the word is still present and pops when enable returns.
- Async reset mid-stream: assert rst between clock edges with channels holding 2,1,0,2 words → out_valid=0 immediately, all counts 0; with DEMUX_STATS_EN, xfer_cnt=0.
